// File: rtl/operand_fetch.sv
// ============================================================================
// Module      : operand_fetch
// Description : Multicycle operand-fetch stage ahead of the ALU. Holds an
//               NREGS x WIDTH register file, reads Rn into operand A and Rm
//               through a 1-bit shifter into operand B, then presents
//               ain/bin/aluop_out to the ALU with a valid/ready handshake.
//               Optional macro OPERAND_FETCH_BYPASS_EN forwards a same-edge
//               register write to the operand being fetched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fetch #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int RSEL  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic [RSEL-1:0]  writenum,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic [RSEL-1:0]  rn,
  input  logic [RSEL-1:0]  rm,
  input  logic [1:0]       shift,
  input  logic [1:0]       aluop,
  input  logic             ready,
  output logic [WIDTH-1:0] ain,
  output logic [WIDTH-1:0] bin,
  output logic [1:0]       aluop_out,
  output logic             valid,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOADA = 2'd1,
    S_LOADB = 2'd2,
    S_VALID = 2'd3
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] regs [NREGS];

  // Request fields captured when a fetch is accepted
  logic [RSEL-1:0] rn_q;
  logic [RSEL-1:0] rm_q;
  logic [1:0]      shift_q;
  logic [1:0]      aluop_q;

  logic [WIDTH-1:0] read_a;
  logic [WIDTH-1:0] read_b;

  // 1-bit shifter; shifted-out bits are dropped, width is preserved
  function automatic logic [WIDTH-1:0] shift_op(input logic [WIDTH-1:0] x,
                                                input logic [1:0]       op);
    case (op)
      2'b01:   shift_op = {x[WIDTH-2:0], 1'b0};
      2'b10:   shift_op = {1'b0, x[WIDTH-1:1]};
      2'b11:   shift_op = {x[WIDTH-1], x[WIDTH-1:1]};
      default: shift_op = x;
    endcase
  endfunction

  // Register file write port, live in every FSM state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write) begin
      regs[writenum] <= data_in;
    end
  end

  // Operand read selection; the bypass build forwards a same-edge write
  always_comb begin
    read_a = regs[rn_q];
    read_b = regs[rm_q];
`ifdef OPERAND_FETCH_BYPASS_EN
    if (write && (writenum == rn_q)) read_a = data_in;
    if (write && (writenum == rm_q)) read_b = data_in;
`endif
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; start is only honoured in IDLE and never queued
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_LOADA;
      S_LOADA: state_next = S_LOADB;
      S_LOADB: state_next = S_VALID;
      S_VALID: if (ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // valid/busy are registered decodes of the upcoming state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      valid <= (state_next == S_VALID);
      busy  <= (state_next != S_IDLE);
    end
  end

  // Capture the request so later changes on rn/rm/shift/aluop do not matter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rn_q    <= '0;
      rm_q    <= '0;
      shift_q <= 2'b00;
      aluop_q <= 2'b00;
    end else if ((state == S_IDLE) && start) begin
      rn_q    <= rn;
      rm_q    <= rm;
      shift_q <= shift;
      aluop_q <= aluop;
    end
  end

  // Operand registers: loaded in LOADA/LOADB, held otherwise (incl. VALID)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ain       <= '0;
      bin       <= '0;
      aluop_out <= 2'b00;
    end else begin
      if (state == S_LOADA) begin
        ain <= read_a;
      end
      if (state == S_LOADB) begin
        bin       <= shift_op(read_b, shift_q);
        aluop_out <= aluop_q;
      end
    end
  end

endmodule

`default_nettype wire
